// File: rtl/sfx_tone_queue.sv
// Tone sequencer: a small FIFO of {half-period, duration} requests played back as a square wave.
// Optional build macro SFX_DECAY_EN adds a per-tone linear amplitude decay.
module sfx_tone_queue #(
   parameter int unsigned        DEPTH    = 4,
   parameter int unsigned        DIV_W    = 22,
   parameter int unsigned        DUR_W    = 26,
   parameter logic signed [15:0] AMP      = 16'sd1000,
   parameter int unsigned        DECAY_SH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [DIV_W-1:0]          req_div,
   input  logic [DUR_W-1:0]          req_dur,
   input  logic                      req_urgent,
   input  logic                      flush,
   output logic signed [15:0]        audio,
   output logic                      busy,
   output logic                      tone_on,
   output logic [$clog2(DEPTH):0]    level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DECAY_SH == 0) begin : g_cfg_invalid
      $error("sfx_tone_queue: DEPTH must be a power of 2 >= 2 and DECAY_SH >= 1");
   end

   typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_e;

   state_e                state_q, state_d;
   logic [DIV_W-1:0]      cur_div_q, cur_div_d;
   logic [DUR_W-1:0]      cur_dur_q, cur_dur_d;
   logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
   logic [DUR_W-1:0]      dur_cnt_q, dur_cnt_d;
   logic                  phase_q, phase_d;
   logic signed [15:0]    audio_q, audio_d;
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]         level_q, level_d;
   logic [DIV_W-1:0]      div_mem [DEPTH];
   logic [DUR_W-1:0]      dur_mem [DEPTH];

   logic                  accept_s, push_s, pop_s, last_s, load_s;
   logic [DIV_W-1:0]      ld_div_s;
   logic [DUR_W-1:0]      ld_dur_s;
   logic signed [15:0]    amp_s;

`ifdef SFX_DECAY_EN
   logic [15:0]           amp_q, amp_d;
   logic [DECAY_SH-1:0]   decay_cnt_q, decay_cnt_d;
   assign amp_s = $signed(amp_q);
`else
   assign amp_s = AMP;
`endif

   // Ready uses the pre-pop level, so a full queue never passes a push through
   assign req_ready = !flush && ((level_q < LW'(DEPTH)) || req_urgent);
   assign accept_s  = req_valid && req_ready;
   assign push_s    = accept_s && !req_urgent;
   assign last_s    = (state_q == PLAY) && (dur_cnt_q == cur_dur_q - {{(DUR_W-1){1'b0}}, 1'b1});

   assign audio   = audio_q;
   assign busy    = (state_q == PLAY);
   assign tone_on = (state_q == PLAY) && (cur_div_q != {DIV_W{1'b0}});
   assign level   = level_q;

   // FIFO storage write port
   always_ff @(posedge clk) begin
      if (push_s) begin
         div_mem[wr_ptr_q] <= req_div;
         dur_mem[wr_ptr_q] <= req_dur;
      end
   end

   // Next-state: flush beats urgent, urgent beats normal queue traffic
   always_comb begin
      state_d   = state_q;
      cur_div_d = cur_div_q;
      cur_dur_d = cur_dur_q;
      div_cnt_d = div_cnt_q;
      dur_cnt_d = dur_cnt_q;
      phase_d   = phase_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      pop_s     = 1'b0;
      load_s    = 1'b0;
      ld_div_s  = req_div;
      ld_dur_s  = req_dur;
`ifdef SFX_DECAY_EN
      amp_d       = amp_q;
      decay_cnt_d = decay_cnt_q;
`endif
      if ((state_q == PLAY) && (cur_div_q != {DIV_W{1'b0}})) begin
         audio_d = phase_q ? amp_s : -amp_s;
      end else begin
         audio_d = 16'sd0;
      end

      if (flush) begin
         state_d  = IDLE;
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         level_d  = {LW{1'b0}};
         audio_d  = 16'sd0;
      end else if (accept_s && req_urgent) begin
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         level_d  = {LW{1'b0}};
         load_s   = 1'b1;
      end else begin
         if (state_q == PLAY) begin
            if (last_s) begin
               if (level_q != {LW{1'b0}}) begin
                  pop_s = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               dur_cnt_d = dur_cnt_q + {{(DUR_W-1){1'b0}}, 1'b1};
               if (cur_div_q == {DIV_W{1'b0}}) begin
                  div_cnt_d = div_cnt_q;
               end else if (div_cnt_q == cur_div_q - {{(DIV_W-1){1'b0}}, 1'b1}) begin
                  div_cnt_d = {DIV_W{1'b0}};
                  phase_d   = !phase_q;
               end else begin
                  div_cnt_d = div_cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
               end
`ifdef SFX_DECAY_EN
               decay_cnt_d = decay_cnt_q + {{(DECAY_SH-1){1'b0}}, 1'b1};
               if ((decay_cnt_q == {DECAY_SH{1'b1}}) && (amp_q != 16'd0)) begin
                  amp_d = amp_q - 16'd1;
               end else begin
                  amp_d = amp_q;
               end
`endif
            end
         end else begin
            pop_s = (level_q != {LW{1'b0}});
         end

         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            ld_div_s = div_mem[rd_ptr_q];
            ld_dur_s = dur_mem[rd_ptr_q];
            load_s   = 1'b1;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         level_d = level_q + LW'(push_s) - LW'(pop_s);
      end

      // A zero-duration entry is dropped here, costing exactly the pop cycle
      if (load_s) begin
         state_d   = (ld_dur_s != {DUR_W{1'b0}}) ? PLAY : IDLE;
         cur_div_d = ld_div_s;
         cur_dur_d = ld_dur_s;
         div_cnt_d = {DIV_W{1'b0}};
         dur_cnt_d = {DUR_W{1'b0}};
         phase_d   = 1'b1;
`ifdef SFX_DECAY_EN
         amp_d       = AMP;
         decay_cnt_d = {DECAY_SH{1'b0}};
`endif
      end else begin
         cur_div_d = cur_div_d;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cur_div_q <= {DIV_W{1'b0}};
         cur_dur_q <= {DUR_W{1'b0}};
         div_cnt_q <= {DIV_W{1'b0}};
         dur_cnt_q <= {DUR_W{1'b0}};
         phase_q   <= 1'b1;
         audio_q   <= 16'sd0;
         wr_ptr_q  <= {AW{1'b0}};
         rd_ptr_q  <= {AW{1'b0}};
         level_q   <= {LW{1'b0}};
`ifdef SFX_DECAY_EN
         amp_q       <= AMP;
         decay_cnt_q <= {DECAY_SH{1'b0}};
`endif
      end else begin
         state_q   <= state_d;
         cur_div_q <= cur_div_d;
         cur_dur_q <= cur_dur_d;
         div_cnt_q <= div_cnt_d;
         dur_cnt_q <= dur_cnt_d;
         phase_q   <= phase_d;
         audio_q   <= audio_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
`ifdef SFX_DECAY_EN
         amp_q       <= amp_d;
         decay_cnt_q <= decay_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_sfx_tone_queue.sv
// Directed bench for sfx_tone_queue: a vector table for single-tone timing plus
// hand-written sequences for queue-full, urgent preemption, flush and async reset.
module tb_sfx_tone_queue;

   logic               clk = 1'b0;
   logic               rst;
   logic               req_valid;
   logic               req_ready;
   logic [21:0]        req_div;
   logic [25:0]        req_dur;
   logic               req_urgent;
   logic               flush;
   logic signed [15:0] audio;
   logic               busy;
   logic               tone_on;
   logic [2:0]         level;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        vld;
      logic [21:0] dv;
      logic [25:0] dr;
      int          aud;
      logic        bsy;
      logic        ton;
      int          lvl;
      logic        rdy;
   } vec_t;

   vec_t tbl [0:63];
   int   n_rows = 0;

   sfx_tone_queue dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_div(req_div), .req_dur(req_dur), .req_urgent(req_urgent), .flush(flush),
      .audio(audio), .busy(busy), .tone_on(tone_on), .level(level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic v, input int dv, input int dr, input int aud,
                      input logic b, input logic t, input int l, input logic r);
      tbl[n_rows].vld = v;
      tbl[n_rows].dv  = 22'(dv);
      tbl[n_rows].dr  = 26'(dr);
      tbl[n_rows].aud = aud;
      tbl[n_rows].bsy = b;
      tbl[n_rows].ton = t;
      tbl[n_rows].lvl = l;
      tbl[n_rows].rdy = r;
      n_rows++;
   endtask

   task automatic push(input int dv, input int dr);
      req_valid = 1'b1;
      req_div   = 22'(dv);
      req_dur   = 26'(dr);
      tick();
      req_valid = 1'b0;
   endtask

   int n;
   int gaps;

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_div = 22'd0; req_dur = 26'd0;
      req_urgent = 1'b0; flush = 1'b0;

      // Tone div=3 dur=12: row i is driven before edge N+i and checked after it
      add(1'b1, 3, 12, 0, 1'b0, 1'b0, 1, 1'b1);
      add(1'b0, 0, 0, 0, 1'b1, 1'b1, 0, 1'b1);
      for (int i = 2; i <= 12; i++) begin
         add(1'b0, 0, 0, ((((i - 2) / 3) % 2) == 0) ? 1000 : -1000, 1'b1, 1'b1, 0, 1'b1);
      end
      add(1'b0, 0, 0, -1000, 1'b0, 1'b0, 0, 1'b1);
      add(1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b1);
      // Rest tone div=0 dur=10
      add(1'b1, 0, 10, 0, 1'b0, 1'b0, 1, 1'b1);
      for (int i = 1; i <= 10; i++) begin
         add(1'b0, 0, 0, 0, 1'b1, 1'b0, 0, 1'b1);
      end
      add(1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b1);
      // Zero-duration entry is discarded without PLAY
      add(1'b1, 4, 0, 0, 1'b0, 1'b0, 1, 1'b1);
      add(1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b1);
      add(1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b1);

      #1;
      chk("ready_in_reset", req_ready, 1);
      chk("audio_in_reset", audio, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("idle_audio", audio, 0);
      chk("idle_busy", busy, 0);
      chk("idle_ready", req_ready, 1);
      chk("idle_level", level, 0);

      for (int i = 0; i < n_rows; i++) begin
         req_valid = tbl[i].vld;
         req_div   = tbl[i].dv;
         req_dur   = tbl[i].dr;
         #1;
         chk($sformatf("row%0d_ready", i), req_ready, tbl[i].rdy);
         @(posedge clk);
         #1;
         req_valid = 1'b0;
         chk($sformatf("row%0d_audio", i), audio, tbl[i].aud);
         chk($sformatf("row%0d_busy", i), busy, tbl[i].bsy);
         chk($sformatf("row%0d_tone_on", i), tone_on, tbl[i].ton);
         chk($sformatf("row%0d_level", i), level, tbl[i].lvl);
      end

      // Queue full during a long tone, then gapless drain of 3+4+5+6 cycles
      push(2, 40);
      tick(); tick();
      for (int k = 0; k < 5; k++) begin
         req_valid = 1'b1;
         req_div   = 22'd1;
         req_dur   = 26'(3 + k);
         #1;
         chk($sformatf("fill%0d_ready", k), req_ready, (k < 4) ? 1 : 0);
         tick();
      end
      req_valid = 1'b0;
      chk("full_level", level, 4);
      chk("full_ready", req_ready, 0);
      req_urgent = 1'b1;
      #1;
      chk("full_urgent_ready", req_ready, 1);
      req_urgent = 1'b0;
      #1;
      gaps = 0;
      n = 0;
      while (level != 3'd3 && n < 100) begin
         if (!busy) gaps++;
         tick();
         n++;
      end
      chk("drain_start_seen", (level == 3'd3) ? 1 : 0, 1);
      chk("long_tone_gaps", gaps, 0);
      n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      chk("drain_busy_cycles", n, 18);
      chk("drain_level", level, 0);

      // Urgent preemption with 3 entries queued
      push(2, 50);
      push(3, 5); push(3, 5); push(3, 5);
      tick(); tick();
      chk("pre_urgent_level", level, 3);
      req_valid = 1'b1; req_urgent = 1'b1; req_div = 22'd5; req_dur = 26'd8;
      #1;
      chk("urgent_ready", req_ready, 1);
      tick();
      req_valid = 1'b0; req_urgent = 1'b0;
      chk("urgent_level", level, 0);
      chk("urgent_busy", busy, 1);
      tick();
      chk("urgent_audio_first", audio, 1000);
      repeat (4) tick();
      chk("urgent_audio_hi_end", audio, 1000);
      tick();
      chk("urgent_audio_lo", audio, -1000);
      tick(); tick();
      chk("urgent_end_busy", busy, 0);
      repeat (4) tick();
      chk("urgent_after_busy", busy, 0);
      chk("urgent_after_audio", audio, 0);
      chk("urgent_after_level", level, 0);

      // flush and a request in the same cycle during PLAY
      push(3, 30);
      push(1, 4); push(1, 4);
      tick(); tick();
      chk("pre_flush_level", level, 2);
      flush = 1'b1; req_valid = 1'b1; req_div = 22'd7; req_dur = 26'd9;
      #1;
      chk("flush_ready", req_ready, 0);
      tick();
      flush = 1'b0; req_valid = 1'b0;
      chk("flush_busy", busy, 0);
      chk("flush_audio", audio, 0);
      chk("flush_level", level, 0);
      tick();
      chk("post_flush_busy", busy, 0);
      chk("post_flush_audio", audio, 0);

      // Asynchronous reset mid-tone
      push(2, 30);
      push(1, 5);
      tick();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_audio", audio, 0);
      chk("arst_level", level, 0);
      chk("arst_ready", req_ready, 1);
      chk("arst_tone_on", tone_on, 0);
      @(negedge clk);
      rst = 1'b0;
      tick(); tick(); tick();
      chk("post_rst_busy", busy, 0);
      chk("post_rst_level", level, 0);
      chk("post_rst_audio", audio, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sfx_tone_queue.md
SFX_TONE_QUEUE -- requirements
Module: sfx_tone_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue depth in entries; SHALL be a power of 2 and at least 2.
REQ-002 Parameter DIV_W, default 22, width of the half-period divider.
REQ-003 Parameter DUR_W, default 26, width of the duration counter.
REQ-004 Parameter AMP, default 16'd1000, peak square-wave amplitude (signed 16-bit).
REQ-005 Parameter DECAY_SH, default 16, log2 of clk cycles per decay step (used only under REQ-031).
REQ-006 clk  in  1  system clock; all logic SHALL be rising-edge.
REQ-007 rst  in  1  reset: asynchronous, active-high.
REQ-008 req_valid  in  1  tone request valid.
REQ-009 req_ready  out  1  request accepted when req_valid && req_ready at a clk edge.
REQ-010 req_div  in  DIV_W  half-period in clk cycles; 0 = rest.
REQ-011 req_dur  in  DUR_W  tone length in clk cycles.
REQ-012 req_urgent  in  1  request preempts playback and clears the queue.
REQ-013 flush  in  1  abort playback and empty the queue.
REQ-014 audio  out  16  signed sample to the speaker serializer.
REQ-015 busy  out  1  high while in PLAY.
REQ-016 tone_on  out  1  high while in PLAY with current div != 0.
REQ-017 level  out  clog2(DEPTH)+1  current queue occupancy.

Function
REQ-018 Queue SHALL be a FIFO of {div,dur}; req_ready = !flush && ((level < DEPTH) || req_urgent), evaluated on the pre-pop level (no pass-through when full).
REQ-019 States IDLE, PLAY; in IDLE with level > 0, the block SHALL pop the head and enter PLAY on the next edge.
REQ-020 Latency: a non-urgent request accepted at edge N into an empty queue in IDLE SHALL produce the first non-zero audio sample at edge N+2.
REQ-021 PLAY SHALL last exactly dur cycles; at the last cycle, if level > 0, the next entry SHALL be popped and played with no gap cycle; otherwise the state SHALL return to IDLE.
REQ-022 Waveform: on entering PLAY the phase SHALL be high; phase SHALL toggle every div cycles; audio = +amp when phase high, -amp when low; audio = 0 outside PLAY or when div = 0.
REQ-023 dur = 0 entries SHALL be discarded on pop without entering PLAY, consuming one cycle.
REQ-024 An urgent accept SHALL clear the queue, abort the current tone, and load the urgent tone directly into PLAY at the next edge (audio non-zero one edge after accept); level stays 0.
REQ-025 flush SHALL clear the queue and force IDLE at the next edge with audio = 0; flush has priority over any request in the same cycle.
REQ-026 Simultaneous push and pop SHALL leave level unchanged; the pointers SHALL wrap modulo DEPTH.
REQ-027 Divider and duration counters SHALL be unsigned, sized DIV_W/DUR_W, with no overflow at maximum values.

Reset
REQ-028 On rst: state = IDLE, queue empty, level = 0, audio = 0, busy = 0, tone_on = 0, phase high, amp = AMP, all counters 0.
REQ-029 rst asserted mid-tone SHALL take effect immediately (asynchronous) and discard all queued entries.
REQ-030 req_ready SHALL be 1 while in reset with flush low.

Configuration
REQ-031 Macro SFX_DECAY_EN defined: amp SHALL load AMP at each tone start and decrement by 1 every 2^DECAY_SH PLAY cycles, saturating at 0.
REQ-032 Macro SFX_DECAY_EN undefined: amp SHALL be the constant AMP and the decay logic SHALL be absent.

Verification
REQ-033 Reset released, idle -> audio = 0, busy = 0, req_ready = 1, level = 0.
REQ-034 Push div = 3, dur = 12 at edge N -> audio +1000 at N+2..N+4, -1000 at N+5..N+7, +1000 at N+8..N+10, -1000 at N+11..N+13, 0 and busy = 0 from N+14.
REQ-035 DEPTH = 4: five back-to-back pushes during a long tone -> level = 4, req_ready = 0, fifth request not accepted; the following tones play with no gaps.
REQ-036 Urgent push (div = 5) mid-tone with 3 entries queued -> level = 0 next edge, new tone +1000 one edge after accept, old entries never played.
REQ-037 Push div = 0, dur = 10 -> busy = 1 and tone_on = 0 for 10 cycles, audio = 0 throughout.
REQ-038 flush and req_valid in the same cycle during PLAY -> request not accepted, IDLE and audio = 0 next edge, level = 0.
